// File: rtl/song_player_if.sv
// song_player_if: control and output bundle of the song sequencer
//   start, stop, loop_en : playback controls (master -> slave)
//   note, led            : buzzer note code and one-hot key LED (slave -> master)
//   busy, done, idx      : status and current ROM entry (slave -> master)
interface song_player_if;
  logic       start;
  logic       stop;
  logic       loop_en;
  logic [4:0] note;
  logic [6:0] led;
  logic       busy;
  logic       done;
  logic [4:0] idx;
  modport master (output start, stop, loop_en, input note, led, busy, done, idx);
  modport slave (input start, stop, loop_en, output note, led, busy, done, idx);
endinterface

// File: rtl/song_player.sv
// song_player: plays a fixed 32-entry ROM song as buzzer note codes with key LEDs
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : song_player_if.slave (start/stop/loop_en in; note/led/busy/done/idx out)
//   UNIT_TICKS : cycles per duration unit (>= 2); GAP_TICKS : silent cycles after each note (>= 1)
module song_player #(
  parameter int UNIT_TICKS = 12_500_000,
  parameter int GAP_TICKS  = 1_250_000
) (
  input logic         clk,
  input logic         rst_n,
  song_player_if.slave bus
);
  typedef enum logic [2:0] {IDLE, FETCH, PLAY, GAP, DONE} state_t;
  localparam logic [31:0] UT = 32'(UNIT_TICKS);
  localparam logic [31:0] GT = 32'(GAP_TICKS);
  state_t      state;
  logic [31:0] cnt;
  logic        wrap;
  logic [4:0]  note_q;
  logic [6:0]  led_q;
  logic        busy_q;
  logic        done_q;
  logic [4:0]  idx_q;
  logic [7:0]  rom;
  logic [4:0]  rom_note;
  logic [2:0]  rom_dur;
  logic [6:0]  rom_led;
  logic [31:0] play_len;
  logic        at_end;
  always_comb begin
    rom = 8'hff;
    case (idx_q)
      5'd0, 5'd1:   rom = 8'h40;
      5'd2, 5'd3:   rom = 8'h60;
      5'd4, 5'd5:   rom = 8'h68;
      5'd6:         rom = 8'h61;
      5'd7, 5'd8:   rom = 8'h58;
      5'd9, 5'd10:  rom = 8'h50;
      5'd11, 5'd12: rom = 8'h48;
      5'd13:        rom = 8'h41;
      default:      rom = 8'hff;
    endcase
  end
  assign rom_note = rom[7:3];
  assign rom_dur  = rom[2:0];
  assign rom_led  = (rom_note >= 5'd8 && rom_note <= 5'd14) ? 7'd1 << (rom_note - 5'd8) : 7'd0;
  assign play_len = ({29'd0, rom_dur} + 32'd1) * UT - 32'd1;
  // a 31->0 index wrap in GAP counts as reaching the end of the song
  assign at_end   = wrap || rom == 8'hff;
  assign bus.note = note_q;
  assign bus.led  = led_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.idx  = idx_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      wrap   <= 1'b0;
      note_q <= '0;
      led_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      idx_q  <= '0;
    end else if (state != IDLE && bus.stop) begin
      state  <= IDLE;
      cnt    <= '0;
      wrap   <= 1'b0;
      note_q <= '0;
      led_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      idx_q  <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start && !bus.stop) begin
          state  <= FETCH;
          busy_q <= 1'b1;
        end
        FETCH: if (at_end) begin
          wrap <= 1'b0;
          if (bus.loop_en) idx_q <= '0;
          else begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end else begin
          note_q <= rom_note;
          led_q  <= rom_led;
          cnt    <= play_len;
          state  <= PLAY;
        end
        PLAY: if (cnt == '0) begin
          state  <= GAP;
          note_q <= '0;
          led_q  <= '0;
          cnt    <= GT - 32'd1;
        end else cnt <= cnt - 32'd1;
        GAP: if (cnt == '0) begin
          state <= FETCH;
          idx_q <= idx_q + 5'd1;
          wrap  <= idx_q == 5'd31;
        end else cnt <= cnt - 32'd1;
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
          idx_q  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_song_player.sv
// tb_song_player: scoreboard bench for song_player with UNIT_TICKS=4, GAP_TICKS=2
module tb_song_player;
  typedef struct packed {
    logic [4:0] note;
    logic [6:0] led;
    logic       busy;
    logic       done;
    logic [4:0] idx;
  } obs_t;
  logic clk = 1'b0;
  logic rst_n;
  int n_checks = 0;
  int n_fail = 0;
  int n_cyc = 0;
  obs_t q[$];
  int song_n[14] = '{8, 8, 12, 12, 13, 13, 12, 11, 11, 10, 10, 9, 9, 8};
  int song_d[14] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
  song_player_if bus ();
  song_player #(.UNIT_TICKS(4), .GAP_TICKS(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic obs_t sample();
    return obs_t'({bus.note, bus.led, bus.busy, bus.done, bus.idx});
  endfunction
  function automatic obs_t mk(int n, logic b, logic d, int i);
    logic [6:0] l;
    l = (n >= 8 && n <= 14) ? 7'(1 << (n - 8)) : 7'd0;
    return obs_t'({5'(n), l, b, d, 5'(i)});
  endfunction
  task automatic check(input string tag, input obs_t got, input obs_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got note=%0d led=%b busy=%b done=%b idx=%0d, expected note=%0d led=%b busy=%b done=%b idx=%0d",
               tag, got.note, got.led, got.busy, got.done, got.idx, exp.note, exp.led, exp.busy, exp.done, exp.idx);
    end
  endtask
  task automatic push_idle(int n);
    repeat (n) q.push_back(mk(0, 1'b0, 1'b0, 0));
  endtask
  task automatic push_entry(int i);
    q.push_back(mk(0, 1'b1, 1'b0, i));
    repeat ((song_d[i] + 1) * 4) q.push_back(mk(song_n[i], 1'b1, 1'b0, i));
    repeat (2) q.push_back(mk(0, 1'b1, 1'b0, i));
  endtask
  task automatic push_pass(bit lp);
    for (int i = 0; i < 14; i++) push_entry(i);
    q.push_back(mk(0, 1'b1, 1'b0, 14));
    if (!lp) q.push_back(mk(0, 1'b1, 1'b1, 14));
  endtask
  task automatic consume(string tag, int n);
    repeat (n) begin
      @(negedge clk);
      n_cyc++;
      if (q.size() != 0) check($sformatf("%s@%0d", tag, n_cyc), sample(), q.pop_front());
    end
  endtask
  task automatic consume_all(string tag);
    while (q.size() != 0) consume(tag, 1);
  endtask
  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.loop_en = 1'b0;
    #3 check("reset", sample(), mk(0, 1'b0, 1'b0, 0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push_idle(2);
    consume_all("idle");
    n_cyc = 0;
    bus.start = 1'b1;
    push_pass(1'b0);
    push_idle(3);
    consume("single", 1);
    bus.start = 1'b0;
    consume_all("single");
    n_cyc = 0;
    bus.loop_en = 1'b1;
    bus.start = 1'b1;
    push_pass(1'b1);
    q.push_back(mk(0, 1'b1, 1'b0, 0));
    repeat (4) q.push_back(mk(8, 1'b1, 1'b0, 0));
    consume("loop", 1);
    bus.start = 1'b0;
    consume_all("loop");
    bus.stop = 1'b1;
    push_idle(1);
    consume_all("loop_stop");
    bus.stop = 1'b0;
    bus.loop_en = 1'b0;
    push_idle(2);
    consume_all("loop_idle");
    n_cyc = 0;
    bus.start = 1'b1;
    push_pass(1'b0);
    consume("stop", 1);
    bus.start = 1'b0;
    consume("stop", 19);
    q.delete();
    bus.stop = 1'b1;
    push_idle(1);
    consume_all("stop_idle");
    bus.stop = 1'b0;
    push_idle(3);
    consume_all("stop_idle");
    n_cyc = 0;
    bus.start = 1'b1;
    push_pass(1'b0);
    push_idle(1);
    consume("restart", 1);
    bus.start = 1'b0;
    consume_all("restart");
    bus.start = 1'b1;
    bus.stop = 1'b1;
    push_idle(3);
    consume_all("collide");
    bus.stop = 1'b0;
    n_cyc = 0;
    push_pass(1'b0);
    push_idle(1);
    q.push_back(mk(0, 1'b1, 1'b0, 0));
    repeat (2) q.push_back(mk(8, 1'b1, 1'b0, 0));
    consume_all("held_start");
    bus.stop = 1'b1;
    push_idle(2);
    consume_all("held_stop");
    bus.start = 1'b0;
    bus.stop = 1'b0;
    n_cyc = 0;
    bus.start = 1'b1;
    push_pass(1'b0);
    consume("pre_rst", 3);
    bus.start = 1'b0;
    q.delete();
    #2 rst_n = 1'b0;
    #1 check("async_reset", sample(), mk(0, 1'b0, 1'b0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    push_idle(2);
    consume_all("post_rst");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
